// File: rtl/clock_div_multi.sv
// clock_div_multi: NUM_CH independent programmable clock dividers.
//   Each channel produces a 50% duty clock of inclk/D (even or odd D),
//   with a runtime-writable divisor applied only at period boundaries.
//
// Ports:
//   inclk        system clock; all state on rising edge except the odd-duty
//                half-cycle flop, which uses the falling edge
//   rst_n        asynchronous active-low reset
//   sync_req     (only with CLKDIV_SYNC_EN) restart every running channel
//   en           per-channel run enable, sampled at period boundaries
//   div_wr       per-channel divisor write strobe
//   div_in       packed divisors, channel i at [i*WIDTH +: WIDTH]
//   outclk       divided clocks
//   tick         one-inclk-cycle pulse at the start of each output period
//   div_pending  a written divisor is waiting for the next boundary
//   cur_div      active divisor per channel, packed like div_in
//
// Build option: define CLKDIV_SYNC_EN to add the sync_req phase-align input.
module clock_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic                    inclk,
  input  logic                    rst_n,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync_req,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       div_wr,
  input  logic [NUM_CH*WIDTH-1:0] div_in,
  output logic [NUM_CH-1:0]       outclk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       div_pending,
  output logic [NUM_CH*WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next_c;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] wr_val_c;
    logic             pend;
    logic             pos_q;
    logic             neg_q;
    logic             tick_q;
    logic             wrap_c;
    logic             bound_c;

    // Divisors below 2 cannot produce a clock; clamp at capture.
    assign wr_val_c   = (div_in[i*WIDTH +: WIDTH] < MIN_DIV) ? MIN_DIV
                                                             : div_in[i*WIDTH +: WIDTH];
    assign cnt_next_c = WIDTH'(cnt + WIDTH'(1));
    assign wrap_c     = (state == RUN) && (cnt == WIDTH'(active - WIDTH'(1)));

`ifdef CLKDIV_SYNC_EN
    // A sync request behaves as an early boundary; coinciding with a natural
    // boundary it is still a single restart.
    assign bound_c = wrap_c || ((state == RUN) && sync_req);
`else
    assign bound_c = wrap_c;
`endif

    // Channel FSM, counter, divisor registers and rising-edge half of outclk.
    always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        cnt     <= '0;
        active  <= DEF_DIV;
        pending <= DEF_DIV;
        pend    <= 1'b0;
        pos_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        case (state)
          IDLE: begin
            if (en[i]) begin
              state  <= RUN;
              cnt    <= '0;
              active <= pending;
              pend   <= 1'b0;
              pos_q  <= 1'b1;
              tick_q <= 1'b1;
            end
          end
          RUN: begin
            if (bound_c) begin
              cnt <= '0;
              if (en[i]) begin
                active <= pending;
                pend   <= 1'b0;
                pos_q  <= 1'b1;
                tick_q <= 1'b1;
              end else begin
                state <= IDLE;
                pos_q <= 1'b0;
              end
            end else begin
              cnt   <= cnt_next_c;
              // High for the first floor(D/2) cycles of the period.
              pos_q <= (cnt_next_c < (active >> 1));
            end
          end
          default: state <= IDLE;
        endcase
        // Capture after the boundary logic so a write on a boundary edge
        // survives as pending for the following boundary.
        if (div_wr[i]) begin
          pending <= wr_val_c;
          pend    <= 1'b1;
        end
      end
    end

    // Odd divisors: stretch the high phase by half a cycle to a falling edge.
    always_ff @(negedge inclk or negedge rst_n) begin
      if (!rst_n) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= pos_q & active[0];
      end
    end

    // Both sources are flops; neg_q only extends an already-high pos_q.
    assign outclk[i]                  = pos_q | neg_q;
    assign tick[i]                    = tick_q;
    assign div_pending[i]             = pend;
    assign cur_div[i*WIDTH +: WIDTH]  = active;
  end

endmodule
